// File: rtl/aqed_dbuf_fc_checker.sv
// A-QED functional-consistency checker with per-frame write/read
// budget gates for double-buffer streams.
module aqed_dbuf_fc_checker #(
  parameter int DATA_W  = 16,
  parameter int DEPTH_W = 16,
  parameter int IDX_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic [DEPTH_W-1:0] depth,
  input  logic               wen_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               exec_dup,
  input  logic               ren_in,
  input  logic               valid_out,
  input  logic [DATA_W-1:0]  data_out,
  output logic               wr_allow,
  output logic               rd_allow,
  output logic               qed_done,
  output logic               qed_check,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    ORIG,
    DUP,
    DONE
  } state_t;

  state_t             state;
  logic               latched;
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] wr_cnt;
  logic [DEPTH_W-1:0] rd_cnt;
  logic [DEPTH_W-1:0] wr_nxt;
  logic [DEPTH_W-1:0] rd_nxt;
  logic [IDX_W-1:0]   in_idx;
  logic [IDX_W-1:0]   out_idx;
  logic [IDX_W-1:0]   orig_idx;
  logic [IDX_W-1:0]   dup_idx;
  logic [DATA_W-1:0]  orig_data;
  logic [DATA_W-1:0]  orig_out;
  logic [DATA_W-1:0]  dup_out;
  logic               got_orig;
  logic               got_dup;
  logic               in_sat;
  logic               out_sat;
  logic               tag_orig;
  logic               tag_dup;
  logic               hit_orig;
  logic               hit_dup;

  // Budget gates; an unlatched or zero depth closes both.
  assign wr_allow = latched && (depth_q != '0) && (wr_cnt != depth_q);
  assign rd_allow = latched && (depth_q != '0) && (rd_cnt != depth_q);

  // Counting only while the gate is open keeps counters <= depth_q.
  assign wr_nxt = wr_cnt + DEPTH_W'(wen_in && wr_allow);
  assign rd_nxt = rd_cnt + DEPTH_W'(ren_in && rd_allow);

  assign in_sat  = &in_idx;
  assign out_sat = &out_idx;

  assign tag_orig = (state == IDLE) && wen_in && exec_dup && !in_sat;
  assign tag_dup  = (state == ORIG) && wen_in && exec_dup && !in_sat &&
                    (data_in == orig_data);

  // A zero-latency output may match the index being tagged this edge.
  assign hit_orig = valid_out && !got_orig &&
                    (((state != IDLE) && (out_idx == orig_idx)) ||
                     (tag_orig && (out_idx == in_idx)));
  assign hit_dup  = valid_out && !got_dup &&
                    (((state == DUP) && (out_idx == dup_idx)) ||
                     (tag_dup && (out_idx == in_idx)));

  // Depth latch, config error, frame counters and stream indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latched <= 1'b0;
      depth_q <= '0;
      cfg_err <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      in_idx  <= '0;
      out_idx <= '0;
    end else if (clk_en) begin
      if (!latched) begin
        latched <= 1'b1;
        depth_q <= depth;
      end else if (depth != depth_q) begin
        cfg_err <= 1'b1;
      end
      if ((wr_nxt == depth_q) && (rd_nxt == depth_q)) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        wr_cnt <= wr_nxt;
        rd_cnt <= rd_nxt;
      end
      if (wen_in && !in_sat)
        in_idx <= in_idx + IDX_W'(1);
      if (valid_out && !out_sat)
        out_idx <= out_idx + IDX_W'(1);
    end
  end

  // Orig/dup tagging, output capture and the final verdict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      orig_data <= '0;
      orig_idx  <= '0;
      dup_idx   <= '0;
      orig_out  <= '0;
      dup_out   <= '0;
      got_orig  <= 1'b0;
      got_dup   <= 1'b0;
      qed_done  <= 1'b0;
      qed_check <= 1'b1;
    end else if (clk_en) begin
      if (hit_orig) begin
        orig_out <= data_out;
        got_orig <= 1'b1;
      end
      if (hit_dup) begin
        dup_out <= data_out;
        got_dup <= 1'b1;
      end
      case (state)
        IDLE: if (tag_orig) begin
          orig_data <= data_in;
          orig_idx  <= in_idx;
          state     <= ORIG;
        end
        ORIG: if (tag_dup) begin
          dup_idx <= in_idx;
          state   <= DUP;
        end
        DUP: if (got_orig && got_dup) begin
          state     <= DONE;
          qed_done  <= 1'b1;
          qed_check <= (orig_out == dup_out);
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule
